// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad: key map, FSM states and named key codes.
package keypad_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StBncP,
    StHold,
    StBncR,
    StGap
  } state_e;

  // Key code -> {row[1:0], col[1:0]}, entries listed from code F down to code 0.
  //   r0: 1 2 3 F   r1: 4 5 6 E   r2: 7 8 9 D   r3: A 0 B C
  localparam logic [15:0][3:0] KEY_MAP = {
    4'h3,  // F
    4'h7,  // E
    4'hB,  // D
    4'hF,  // C
    4'hE,  // B
    4'hC,  // A
    4'hA,  // 9
    4'h9,  // 8
    4'h8,  // 7
    4'h6,  // 6
    4'h5,  // 5
    4'h4,  // 4
    4'h2,  // 3
    4'h1,  // 2
    4'h0,  // 1
    4'hD   // 0
  };

  // Calculator function keys.
  localparam logic [3:0] KEY_OP_0  = 4'hF;
  localparam logic [3:0] KEY_OP_1  = 4'hE;
  localparam logic [3:0] KEY_OP_2  = 4'hD;
  localparam logic [3:0] KEY_OP_3  = 4'hC;
  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_EXEC  = 4'hB;

  function automatic logic [1:0] key_row(input logic [3:0] code);
    logic [3:0] rc;
    rc = KEY_MAP[code];
    return rc[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    logic [3:0] rc;
    rc = KEY_MAP[code];
    return rc[1:0];
  endfunction

endpackage

// File: rtl/keypad_emulator_bounce_gen.sv
// Contact-bounce timing: half-period counter plus pair counter. Reports the contact level
// for the next cycle and flags the final cycle of the pattern.
module bounce_gen #(
  parameter int unsigned BOUNCE_CYC = 4,
  parameter int unsigned BOUNCE_N   = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic invert,     // 0: closed half first (press), 1: open half first (release)
  output logic level_nxt,
  output logic last
);

  localparam int unsigned CW = (BOUNCE_CYC > 1) ? $clog2(BOUNCE_CYC) : 1;
  localparam int unsigned PW = (BOUNCE_N > 1) ? $clog2(BOUNCE_N) : 1;

  logic [CW-1:0] cnt_q;
  logic [PW-1:0] pair_q;
  logic          half_q;
  logic          run_q;
  logic          half_end;
  logic          half_nxt;

  assign half_end  = run_q & (cnt_q == CW'(BOUNCE_CYC - 1));
  assign half_nxt  = half_end ? ~half_q : half_q;
  assign level_nxt = half_nxt ? invert : ~invert;
  assign last      = half_end & half_q & (pair_q == PW'(BOUNCE_N - 1));

  // Advance half-period and pair counters while a pattern is running.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      cnt_q  <= '0;
      pair_q <= '0;
      half_q <= 1'b0;
      run_q  <= start & ~reset;
    end else if (run_q) begin
      if (last) begin
        cnt_q  <= '0;
        pair_q <= '0;
        half_q <= 1'b0;
        run_q  <= 1'b0;
      end else if (half_end) begin
        cnt_q  <= '0;
        half_q <= ~half_q;
        if (half_q) pair_q <= pair_q + 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// Switch-matrix side of a 4x4 membrane keypad: closes the commanded key's contact (with
// bounce) so the scanner sees the row pulled low while it drives that key's column.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYC  = 4,
  parameter int unsigned BOUNCE_N    = 3,
  parameter int unsigned HOLD_SCANS  = 4,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       press_req,
  input  logic [3:0] key_code,
  input  logic [3:0] cols_n,
  output logic [3:0] rows_n,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int unsigned SW = (HOLD_SCANS > 1) ? $clog2(HOLD_SCANS) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e        state_q;
  logic          contact_q;
  logic [1:0]    row_q;
  logic [1:0]    col_q;
  logic [3:0]    cols_q;
  logic [SW-1:0] scan_q;
  logic [TW-1:0] to_q;
  logic [GW-1:0] gap_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;

  logic fall;
  logic scans_done;
  logic timed_out;
  logic hold_exit;
  logic bg_start;
  logic bg_invert;
  logic bg_level;
  logic bg_last;

  assign fall       = cols_q[col_q] & ~cols_n[col_q];
  assign scans_done = fall & (scan_q == SW'(HOLD_SCANS - 1));
  assign timed_out  = ~fall & (to_q == TW'(TIMEOUT_CYC - 1));
  assign hold_exit  = (state_q == StHold) & (scans_done | timed_out);
  assign bg_start   = ((state_q == StIdle) & press_req) | hold_exit;
  assign bg_invert  = (state_q != StBncP);

  bounce_gen #(
    .BOUNCE_CYC (BOUNCE_CYC),
    .BOUNCE_N   (BOUNCE_N)
  ) u_bounce_gen (
    .clk       (CLOCK_50),
    .reset     (reset),
    .start     (bg_start),
    .invert    (bg_invert),
    .level_nxt (bg_level),
    .last      (bg_last)
  );

  // Registered copy of the column drive for falling-edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (reset) cols_q <= 4'hF;
    else       cols_q <= cols_n;
  end

  // Press-sequence FSM with registered contact and status outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= StIdle;
      contact_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      scan_q    <= '0;
      to_q      <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (press_req) begin
            row_q     <= key_row(key_code);
            col_q     <= key_col(key_code);
            busy_q    <= 1'b1;
            err_q     <= 1'b0;
            contact_q <= 1'b1;
            scan_q    <= '0;
            to_q      <= '0;
            state_q   <= (BOUNCE_N == 0) ? StHold : StBncP;
          end
        end
        StBncP: begin
          if (bg_last) begin
            contact_q <= 1'b1;
            scan_q    <= '0;
            to_q      <= '0;
            state_q   <= StHold;
          end else begin
            contact_q <= bg_level;
          end
        end
        StHold: begin
          if (hold_exit) begin
            if (timed_out) err_q <= 1'b1;
            contact_q <= 1'b0;
            gap_q     <= '0;
            state_q   <= (BOUNCE_N == 0) ? StGap : StBncR;
          end else if (fall) begin
            scan_q <= scan_q + 1'b1;
            to_q   <= '0;
          end else begin
            to_q <= to_q + 1'b1;
          end
        end
        StBncR: begin
          if (bg_last) begin
            contact_q <= 1'b0;
            gap_q     <= '0;
            state_q   <= StGap;
          end else begin
            contact_q <= bg_level;
          end
        end
        StGap: begin
          if (gap_q == GW'(GAP_CYC - 1)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StIdle;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Zero-latency switch path: only the latched row follows the latched column.
  always_comb begin
    rows_n        = 4'hF;
    rows_n[row_q] = ~(contact_q & ~cols_n[col_q]);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: one instance without bounce (a), one with
// default bounce and a short hold timeout (b).
module tb_keypad_emulator;

  typedef struct {
    logic [3:0] code;
    logic [3:0] rows_exp;
    logic [3:0] cols_exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cols_n;
  logic       press_a, press_b;
  logic [3:0] key_a, key_b;
  logic [3:0] rows_a, rows_b;
  logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

  int          total;
  int          bad;
  int          n, ndone, wrong, lows;
  bit          rot;
  bit          seen;
  logic [31:0] ccnt;
  logic [3:0]  exp;
  vec_t        tbl[16];

  always #5 clk = ~clk;

  keypad_emulator #(
    .BOUNCE_CYC  (4),
    .BOUNCE_N    (0),
    .HOLD_SCANS  (2),
    .GAP_CYC     (8),
    .TIMEOUT_CYC (1000)
  ) dut_a (
    .CLOCK_50  (clk),
    .reset     (reset),
    .press_req (press_a),
    .key_code  (key_a),
    .cols_n    (cols_n),
    .rows_n    (rows_a),
    .busy      (busy_a),
    .done      (done_a),
    .err       (err_a)
  );

  keypad_emulator #(
    .BOUNCE_CYC  (4),
    .BOUNCE_N    (3),
    .HOLD_SCANS  (4),
    .GAP_CYC     (8),
    .TIMEOUT_CYC (100)
  ) dut_b (
    .CLOCK_50  (clk),
    .reset     (reset),
    .press_req (press_b),
    .key_code  (key_b),
    .cols_n    (cols_n),
    .rows_n    (rows_b),
    .busy      (busy_b),
    .done      (done_b),
    .err       (err_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // One clock; in rotate mode a 1-of-4 low column advances every 8 cycles.
  task automatic step();
    @(posedge clk);
    #1;
    if (rot) begin
      ccnt++;
      cols_n = ~(4'b0001 << ccnt[4:3]);
    end
    #1;
  endtask

  task automatic set_cols(input logic [3:0] v);
    cols_n = v;
    #1;
  endtask

  initial begin
    tbl[0]  = '{4'h0, 4'b0111, 4'b1101};
    tbl[1]  = '{4'h1, 4'b1110, 4'b1110};
    tbl[2]  = '{4'h2, 4'b1110, 4'b1101};
    tbl[3]  = '{4'h3, 4'b1110, 4'b1011};
    tbl[4]  = '{4'h4, 4'b1101, 4'b1110};
    tbl[5]  = '{4'h5, 4'b1101, 4'b1101};
    tbl[6]  = '{4'h6, 4'b1101, 4'b1011};
    tbl[7]  = '{4'h7, 4'b1011, 4'b1110};
    tbl[8]  = '{4'h8, 4'b1011, 4'b1101};
    tbl[9]  = '{4'h9, 4'b1011, 4'b1011};
    tbl[10] = '{4'hA, 4'b0111, 4'b1110};
    tbl[11] = '{4'hB, 4'b0111, 4'b1011};
    tbl[12] = '{4'hC, 4'b0111, 4'b0111};
    tbl[13] = '{4'hD, 4'b1011, 4'b0111};
    tbl[14] = '{4'hE, 4'b1101, 4'b0111};
    tbl[15] = '{4'hF, 4'b1110, 4'b0111};

    total = 0; bad = 0; rot = 1'b0; ccnt = '0;
    reset = 1'b1; press_a = 1'b0; press_b = 1'b0; key_a = '0; key_b = '0;
    cols_n = 4'h0;
    step(); step();

    // Reset state, with every column driven low.
    chk("rst_rows_a", rows_a, 4'hF);
    chk("rst_rows_b", rows_b, 4'hF);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_err_b", err_b, 0);
    reset = 1'b0;
    set_cols(4'hF);
    step();

    // Key 5 without bounce; falling edge in the acceptance cycle is not counted.
    key_a = 4'h5;
    set_cols(4'b1101);
    chk("t1_idle_rows", rows_a, 4'hF);
    press_a = 1'b1;
    step();
    press_a = 1'b0;
    key_a = 4'h0;
    chk("t1_busy", busy_a, 1);
    chk("t1_closed", rows_a, 4'b1101);
    set_cols(4'hF);    chk("t1_col_high", rows_a, 4'hF);   step();
    set_cols(4'b1110); chk("t1_other_col", rows_a, 4'hF);  step();
    set_cols(4'b1101); chk("t1_scan1", rows_a, 4'b1101);   step();
    set_cols(4'hF);    chk("t1_col_high2", rows_a, 4'hF);  step();
    set_cols(4'b1101); chk("t1_scan2", rows_a, 4'b1101);   step();
    chk("t1_released", rows_a, 4'hF);
    chk("t1_busy_gap", busy_a, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_no_early_done", done_a, 0);
      step();
    end
    chk("t1_done", done_a, 1);
    chk("t1_busy_done", busy_a, 0);
    chk("t1_err", err_a, 0);
    step();
    chk("t1_done_pulse", done_a, 0);

    // Hold timeout on instance b: columns never activate.
    set_cols(4'hF);
    key_b = 4'hC;
    press_b = 1'b1;
    step();
    press_b = 1'b0;
    chk("t3_busy", busy_b, 1);
    n = 0;
    wrong = 0;
    while (!done_b && n < 400) begin
      if (rows_b !== 4'hF) wrong++;
      step();
      n++;
    end
    chk("t3_latency", n, 156);
    chk("t3_rows", wrong, 0);
    chk("t3_err", err_b, 1);
    chk("t3_busy_done", busy_b, 0);
    step();
    chk("t3_err_hold", err_b, 1);
    chk("t3_done_pulse", done_b, 0);

    // Key F with default bounce at press and release.
    set_cols(4'b0111);
    key_b = 4'hF;
    press_b = 1'b1;
    step();
    press_b = 1'b0;
    chk("t2_err_clr", err_b, 0);
    for (int j = 1; j <= 24; j++) begin
      exp = (((j - 1) / 4) % 2 == 0) ? 4'b1110 : 4'hF;
      chk("t2_press_bnc", rows_b, exp);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      set_cols(4'hF);    chk("t2_hold_col_high", rows_b, 4'hF);   step();
      set_cols(4'b0111); chk("t2_hold", rows_b, 4'b1110);         step();
    end
    for (int j = 1; j <= 24; j++) begin
      exp = (((j - 1) / 4) % 2 == 1) ? 4'b1110 : 4'hF;
      chk("t2_rel_bnc", rows_b, exp);
      step();
    end
    for (int g = 0; g < 8; g++) begin
      chk("t2_gap_rows", rows_b, 4'hF);
      chk("t2_gap_done", done_b, 0);
      step();
    end
    chk("t2_done", done_b, 1);
    chk("t2_busy_done", busy_b, 0);
    chk("t2_err", err_b, 0);
    step();

    // Reset during press bounce aborts without done.
    set_cols(4'b1110);
    key_b = 4'h1;
    press_b = 1'b1;
    step();
    press_b = 1'b0;
    chk("t5_closed", rows_b, 4'b1110);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_rows", rows_b, 4'hF);
    chk("t5_busy", busy_b, 0);
    chk("t5_done", done_b, 0);
    chk("t5_err", err_b, 0);
    seen = 1'b0;
    wrong = 0;
    for (int i = 0; i < 200; i++) begin
      if (done_b) seen = 1'b1;
      if (rows_b !== 4'hF) wrong++;
      step();
    end
    chk("t5_no_done", seen, 0);
    chk("t5_rows_idle", wrong, 0);

    // Key A held; a second request (key 9) mid-hold is ignored.
    set_cols(4'hF);
    step();
    rot = 1'b1;
    ccnt = '0;
    key_a = 4'hA;
    press_a = 1'b1;
    step();
    press_a = 1'b0;
    n = 0; ndone = 0; wrong = 0; lows = 0;
    while (n < 300) begin
      if (n == 10) begin
        key_a = 4'h9;
        press_a = 1'b1;
      end else begin
        press_a = 1'b0;
      end
      if (n == 11) chk("t4_busy_hold", busy_a, 1);
      if (rows_a !== 4'hF) begin
        if (rows_a === 4'b0111 && cols_n === 4'b1110) lows++;
        else wrong++;
      end
      if (done_a) ndone++;
      step();
      n++;
    end
    press_a = 1'b0;
    chk("t4_one_done", ndone, 1);
    chk("t4_wrong_rows", wrong, 0);
    chk("t4_row3_seen", (lows > 0), 1);

    // All 16 codes back to back, each request issued in the previous done cycle.
    key_a = tbl[0].code;
    press_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      press_a = 1'b0;
      chk("t6_busy", busy_a, 1);
      n = 0; wrong = 0; lows = 0;
      while (!done_a && n < 300) begin
        if (rows_a !== 4'hF) begin
          if (rows_a === tbl[i].rows_exp && cols_n === tbl[i].cols_exp) lows++;
          else wrong++;
        end
        step();
        n++;
      end
      chk("t6_done", done_a, 1);
      chk("t6_err", err_a, 0);
      chk("t6_wrong_rows", wrong, 0);
      chk("t6_row_seen", (lows > 0), 1);
      if (i < 15) begin
        key_a = tbl[i + 1].code;
        press_a = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Cycle-accurate model of the 4x4 membrane keypad on GPIO_0, acting as the switch-matrix side of the scan interface. It watches the scanner's active-low column drive and pulls the matching row low while a commanded key is "pressed", including contact bounce at press and release. It sits in place of the physical keypad for loopback self-test on the board and as the stimulus model in scanner and calculator benches.

## Interface
- BOUNCE_CYC, 4: clock cycles per bounce half-period.
- BOUNCE_N, 3: open/closed bounce pairs at press and at release; 0 disables bounce.
- HOLD_SCANS, 4: target-column activations observed while the contact is held steady closed.
- GAP_CYC, 8: cycles the contact stays open after release before `done`.
- TIMEOUT_CYC, 1000000: maximum cycles in HOLD without a target-column activation.
- CLOCK_50  in  1  system clock; `cols_n` is synchronous to it.
- reset  in  1  synchronous, active-high.
- press_req  in  1  single-cycle request to press `key_code`.
- key_code  in  4  hex key value, 0x0–0xF.
- cols_n  in  4  scanner column drive, active-low.
- rows_n  out  4  row lines to the scanner, active-low; 1 means pulled up.
- busy  out  1  high while a press sequence is in progress.
- done  out  1  one-cycle pulse when a sequence completes.
- err  out  1  valid with `done`; 1 means the sequence hit the hold timeout.

## Operation
- The key map is fixed, listed as (row: cols 0..3).
  - r0: 1 2 3 F
  - r1: 4 5 6 E
  - r2: 7 8 9 D
  - r3: A 0 B C
  - `key_code` is translated to (r, c) on acceptance and latched.
- Registered contact bit `contact`.
- Row output: `rows_n[r] = ~(contact & ~cols_n[c])`. All other rows are 1.
  - The path is combinational, so rows follow columns with zero latency, like a real switch.
  - Other low columns are ignored.
- FSM states:
  - IDLE: contact 0. `press_req` is accepted here; go to BNC_P, or to HOLD if BOUNCE_N=0.
  - BNC_P: contact is closed BOUNCE_CYC, then open BOUNCE_CYC, repeated BOUNCE_N times; then go to HOLD.
  - HOLD: contact 1. Count falling edges of `cols_n[c]` (1→0, using a registered copy). At the HOLD_SCANS-th edge, go to BNC_R. The timeout counter is reset on each edge; at TIMEOUT_CYC set `err` and go to BNC_R.
  - BNC_R: contact is open BOUNCE_CYC, then closed BOUNCE_CYC, repeated BOUNCE_N times; then go to GAP.
  - GAP: contact 0 for GAP_CYC cycles; then go to IDLE with `done`=1.
- `press_req` while busy is ignored. There is no queue and no error.
- `key_code` changes after acceptance have no effect.
- A falling edge present in the acceptance cycle is not counted.
- Reset mid-sequence: at the next edge the state is IDLE, contact is 0, all counters are 0, and busy/done/err are 0. No `done` is issued for the aborted sequence.
- `err` holds its value until the next acceptance clears it.

## Timing
- Reset values: `rows_n`=4'hF (for any `cols_n`), busy=0, done=0, err=0.
- `press_req` sampled at edge T: busy=1 and contact=1 from T+1.
- Press bounce spans exactly 2·BOUNCE_N·BOUNCE_CYC cycles; HOLD is entered at T+1+2·BOUNCE_N·BOUNCE_CYC.
- The HOLD_SCANS-th edge sampled at edge H: contact=0 from H+1.
- Release bounce spans 2·BOUNCE_N·BOUNCE_CYC cycles, followed by GAP_CYC open cycles.
- `done` is high for one cycle, with busy=0 in that same cycle.
- A new `press_req` is accepted in the `done` cycle.

## Structure
- Package `keypad_pkg` holds:
  - the 16-entry key map as a constant (code → {row, col});
  - the state enum;
  - the key codes for the operator, clear and execute keys (F, E, D, C, A, B).
- The future scanner refactor uses the same package.
- One sub-module, `bounce_gen`: a half-period counter plus a pair counter, with start and invert-phase inputs. It is instantiated once and shared by BNC_P and BNC_R.

## Test plan
- Key '5', BOUNCE_N=0, HOLD_SCANS=2, with a 1-of-4 rotating low column every 8 cycles:
  - `rows_n`=4'b1101 exactly while `cols_n`=4'b1101, else 4'hF;
  - `done` after 2 col-1 activations plus 8 cycles;
  - err=0.
- Key 'F' with default bounce:
  - row 0 with col 3 toggles every 4 cycles, 3 times, at press and again at release;
  - steady closed between;
  - done=1 after the GAP.
- `cols_n` held at 4'hF with TIMEOUT_CYC=100: `done` with err=1 at 100 cycles plus release bounce plus GAP.
- Second `press_req` (key '9') mid-HOLD of key 'A': ignored; only row 3/col 0 ever pulls low; one `done`.
- Reset asserted in BNC_P: next cycle `rows_n`=4'hF and busy=0; no `done` appears.
- All 16 codes back-to-back through the real scanner: the scanner's `value` equals `key_code` with exactly one `key_press` rising edge per sequence.
